// File: rtl/posit_check_pkg.sv
// Shared definitions for the posit result checker: opcode encodings and the
// layout of one in-flight issue record.
package posit_check_pkg;

    localparam int POSIT_W_DEF = 8;
    localparam int CNT_W_DEF   = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef struct packed {
        logic [CNT_W_DEF-1:0]   seq;
        logic [1:0]             opcode;
        logic [POSIT_W_DEF-1:0] a;
        logic [POSIT_W_DEF-1:0] b;
        logic [POSIT_W_DEF-1:0] expected;
    } posit_entry_t;

    function automatic int entry_width(input int pw, input int cw);
        return cw + 2 + 3 * pw;
    endfunction

endpackage

// File: rtl/posit_check_fifo.sv
// In-order FIFO of issued operations; a push is accepted while full when a
// pop happens in the same cycle.
module posit_check_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic              push_ok_s, pop_ok_s;

    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign occupancy_o = wr_ptr_q - rd_ptr_q;
    assign pop_ok_s    = pop_i & ~empty_o;
    assign push_ok_s   = push_i & (~full_o | pop_ok_s);
    assign rdata_o     = mem_q[rd_ptr_q[AW-1:0]];

    // Storage write; when full the tail slot is the head slot, read out before this edge.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/posit_result_checker.sv
// Result-side self-check for posit_top: queues each issue with its golden
// value, compares on done, counts passes/mismatches and captures the first mismatch.
module posit_result_checker
    import posit_check_pkg::*;
#(
    parameter int posit_width = 8,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      start,
    input  logic [1:0]                opcode,
    input  logic [posit_width-1:0]    a,
    input  logic [posit_width-1:0]    b,
    input  logic [posit_width-1:0]    expected,
    input  logic                      done,
    input  logic [posit_width-1:0]    result,
    input  logic                      zero,
    output logic [CNT_W-1:0]          pass_count,
    output logic [CNT_W-1:0]          err_count,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      err_valid,
    output logic [CNT_W-1:0]          err_index,
    output logic [1:0]                err_opcode,
    output logic [posit_width-1:0]    err_a,
    output logic [posit_width-1:0]    err_b,
    output logic [posit_width-1:0]    err_expected,
    output logic [posit_width-1:0]    err_got
);
    localparam int ENT_W = entry_width(posit_width, CNT_W);

    typedef struct packed {
        logic [CNT_W-1:0]       seq;
        logic [1:0]             opcode;
        logic [posit_width-1:0] a;
        logic [posit_width-1:0] b;
        logic [posit_width-1:0] expected;
    } entry_t;

    typedef struct packed {
        logic [CNT_W-1:0]       seq;
        logic [CNT_W-1:0]       pass;
        logic [CNT_W-1:0]       err;
        logic                   ovf;
        logic                   udf;
        logic                   ev;
        entry_t                 first;
        logic [posit_width-1:0] got;
    } state_t;

    state_t st_q, st_d;
    entry_t wr_entry_s, head_s;
    logic   flush_s, push_s, pop_s, full_s, empty_s, mismatch_s;

    assign flush_s    = reset | clear;
    assign push_s     = start & ~flush_s;
    assign pop_s      = done & ~empty_s & ~flush_s;
    assign wr_entry_s = '{seq: st_q.seq, opcode: opcode, a: a, b: b, expected: expected};
    assign mismatch_s = (result != head_s.expected) || (zero != (result == {posit_width{1'b0}}));

    posit_check_fifo #(.DATA_W(ENT_W), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (flush_s),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .wdata_i     (wr_entry_s),
        .rdata_o     (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .occupancy_o (occupancy)
    );

    // Next-state: sequence numbering, sticky flags, saturating counters, first-mismatch capture.
    always_comb begin
        st_d = st_q;
        if (clear) begin
            st_d = '0;
        end else begin
            if (start) begin
                st_d.seq = st_q.seq + CNT_W'(1);
            end else begin
                st_d.seq = st_q.seq;
            end
            if (start && full_s && !pop_s) begin
                st_d.ovf = 1'b1;
            end else begin
                st_d.ovf = st_q.ovf;
            end
            if (done && empty_s) begin
                st_d.udf = 1'b1;
            end else begin
                st_d.udf = st_q.udf;
            end
            if (pop_s && mismatch_s) begin
                if (!(&st_q.err)) begin
                    st_d.err = st_q.err + CNT_W'(1);
                end else begin
                    st_d.err = st_q.err;
                end
                if (!st_q.ev) begin
                    st_d.ev    = 1'b1;
                    st_d.first = head_s;
                    st_d.got   = result;
                end else begin
                    st_d.ev = st_q.ev;
                end
            end else if (pop_s) begin
                if (!(&st_q.pass)) begin
                    st_d.pass = st_q.pass + CNT_W'(1);
                end else begin
                    st_d.pass = st_q.pass;
                end
            end else begin
                st_d.pass = st_q.pass;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign pass_count   = st_q.pass;
    assign err_count    = st_q.err;
    assign overflow     = st_q.ovf;
    assign underflow    = st_q.udf;
    assign err_valid    = st_q.ev;
    assign err_index    = st_q.first.seq;
    assign err_opcode   = st_q.first.opcode;
    assign err_a        = st_q.first.a;
    assign err_b        = st_q.first.b;
    assign err_expected = st_q.first.expected;
    assign err_got      = st_q.got;

endmodule

// File: tb/tb_posit_result_checker.sv
// Bench for posit_result_checker: directed boundary scenarios plus random
// traffic, every cycle checked against a queue-based reference model.
module tb_posit_result_checker;
    import posit_check_pkg::*;

    localparam int PW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic clk, reset, clear, start, done, zero;
    logic [1:0] opcode;
    logic [PW-1:0] a, b, expected, result;
    logic [CW-1:0] pass_count, err_count, err_index;
    logic [$clog2(DEPTH):0] occupancy;
    logic overflow, underflow, err_valid;
    logic [1:0] err_opcode;
    logic [PW-1:0] err_a, err_b, err_expected, err_got;

    posit_result_checker #(.posit_width(PW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .opcode(opcode),
        .a(a), .b(b), .expected(expected), .done(done), .result(result), .zero(zero),
        .pass_count(pass_count), .err_count(err_count), .occupancy(occupancy),
        .overflow(overflow), .underflow(underflow), .err_valid(err_valid),
        .err_index(err_index), .err_opcode(err_opcode), .err_a(err_a), .err_b(err_b),
        .err_expected(err_expected), .err_got(err_got)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: an ordered list of outstanding issues and plain counters.
    typedef struct { int seq; int op; int a; int b; int ex; } ment_t;
    ment_t mq[$];
    ment_t m_first;
    int m_seq, m_pass, m_err, m_got;
    bit m_ovf, m_udf, m_ev;

    task automatic model_step();
        int occ;
        bit popped;
        ment_t e;
        bit bad;
        if (reset || clear) begin
            mq.delete();
            m_seq = 0; m_pass = 0; m_err = 0; m_got = 0;
            m_ovf = 0; m_udf = 0; m_ev = 0;
            m_first = '{0, 0, 0, 0, 0};
        end else begin
            occ = mq.size();
            popped = 0;
            if (done) begin
                if (occ > 0) begin
                    e = mq.pop_front();
                    popped = 1;
                    bad = (int'(result) != e.ex) || (zero != (result == 8'h00));
                    if (bad) begin
                        if (m_err < 65535) m_err++;
                        if (!m_ev) begin m_ev = 1; m_first = e; m_got = int'(result); end
                    end else if (m_pass < 65535) m_pass++;
                end else m_udf = 1;
            end
            if (start) begin
                if (occ < DEPTH || popped) mq.push_back('{m_seq, int'(opcode), int'(a), int'(b), int'(expected)});
                else m_ovf = 1;
                m_seq = (m_seq + 1) % 65536;
            end
        end
    endtask

    task automatic check_all();
        check_val("pass_count", 32'(pass_count), m_pass);
        check_val("err_count", 32'(err_count), m_err);
        check_val("occupancy", 32'(occupancy), mq.size());
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        check_val("underflow", 32'(underflow), 32'(m_udf));
        check_val("err_valid", 32'(err_valid), 32'(m_ev));
        check_val("err_index", 32'(err_index), m_first.seq);
        check_val("err_opcode", 32'(err_opcode), m_first.op);
        check_val("err_a", 32'(err_a), m_first.a);
        check_val("err_b", 32'(err_b), m_first.b);
        check_val("err_expected", 32'(err_expected), m_first.ex);
        check_val("err_got", 32'(err_got), m_got);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic cyc(input bit st, input bit dn, input logic [1:0] op, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] ex, input logic [7:0] res, input bit z);
        start = st; done = dn; opcode = op; a = av; b = bv; expected = ex; result = res; zero = z;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1'b0, 1'b0, OP_ADD, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        clear = 1'b0;
    endtask

    logic [7:0] pexp [$];
    logic [7:0] pipe_exp [20];
    int peak;
    logic [7:0] r;

    initial begin
        reset = 1'b1; clear = 1'b0;
        cyc(1'b1, 1'b1, OP_ADD, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        reset = 1'b0;
        check_val("reset_pass", 32'(pass_count), 0);
        check_val("reset_occ", 32'(occupancy), 0);

        // Basic pass
        cyc(1'b1, 1'b0, OP_ADD, 8'h40, 8'h40, 8'h50, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, OP_ADD, 8'h00, 8'h00, 8'h00, 8'h50, 1'b0);
        check_val("basic_pass", 32'(pass_count), 1);
        check_val("basic_occ", 32'(occupancy), 0);

        // Mismatch capture
        do_clear();
        cyc(1'b1, 1'b0, OP_ADD, 8'h40, 8'h40, 8'h50, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, OP_SUB, 8'h40, 8'h40, 8'h00, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, OP_MUL, 8'h40, 8'h48, 8'h48, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, OP_ADD, 8'h00, 8'h00, 8'h00, 8'h50, 1'b0);
        cyc(1'b0, 1'b1, OP_ADD, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, OP_ADD, 8'h00, 8'h00, 8'h00, 8'h49, 1'b0);
        check_val("mm_err_count", 32'(err_count), 2);
        check_val("mm_pass_count", 32'(pass_count), 1);
        check_val("mm_err_index", 32'(err_index), 1);
        check_val("mm_err_opcode", 32'(err_opcode), 32'(OP_SUB));
        check_val("mm_err_expected", 32'(err_expected), 0);
        check_val("mm_err_got", 32'(err_got), 0);
        check_val("mm_err_valid", 32'(err_valid), 1);

        // Fixed-latency pipeline: done trails start by 4 cycles
        do_clear();
        peak = 0;
        foreach (pipe_exp[i]) pipe_exp[i] = 8'($urandom_range(1, 255));
        for (int i = 0; i < 24; i++) begin
            cyc(i < 20, i >= 4, OP_MUL, 8'(i), 8'(i + 1), (i < 20) ? pipe_exp[i] : 8'h00,
                (i >= 4) ? pipe_exp[i - 4] : 8'h00, 1'b0);
            if (int'(occupancy) > peak) peak = int'(occupancy);
        end
        check_val("pipe_pass", 32'(pass_count), 20);
        check_val("pipe_peak", 32'(peak), 4);
        check_val("pipe_ovf_udf", {30'd0, overflow, underflow}, 0);

        // Full boundary
        do_clear();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, OP_DIV, 8'(i), 8'h01, 8'(i + 8'h10), 8'h00, 1'b0);
        cyc(1'b1, 1'b1, OP_DIV, 8'h77, 8'h01, 8'h20, 8'h10, 1'b0);
        check_val("full_pushpop_ovf", 32'(overflow), 0);
        check_val("full_pushpop_occ", 32'(occupancy), 8);
        cyc(1'b1, 1'b0, OP_DIV, 8'h78, 8'h01, 8'h21, 8'h00, 1'b0);
        check_val("full_push_ovf", 32'(overflow), 1);
        check_val("full_push_occ", 32'(occupancy), 8);

        // Empty boundary
        do_clear();
        cyc(1'b1, 1'b1, OP_ADD, 8'h40, 8'h40, 8'h50, 8'h50, 1'b0);
        check_val("empty_udf", 32'(underflow), 1);
        check_val("empty_occ", 32'(occupancy), 1);
        check_val("empty_cnts", 32'(pass_count) + 32'(err_count), 0);

        // Reset mid-stream
        do_clear();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, OP_SUB, 8'(i), 8'h02, 8'h30, 8'h00, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b1, OP_SUB, 8'h00, 8'h00, 8'h00, 8'h30, 1'b0);
        reset = 1'b0;
        check_val("rst_occ", 32'(occupancy), 0);
        check_val("rst_pass", 32'(pass_count), 0);
        cyc(1'b0, 1'b1, OP_SUB, 8'h00, 8'h00, 8'h00, 8'h30, 1'b0);
        check_val("rst_then_done_udf", 32'(underflow), 1);

        // Random traffic with occasional corruption, stalls and clears
        do_clear();
        pexp.delete();
        for (int i = 0; i < 2000; i++) begin
            clear = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 1) == 1);
            opcode = 2'($urandom);
            a = 8'($urandom); b = 8'($urandom);
            expected = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            done = (pexp.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 49) == 0);
            if (done && pexp.size() > 0) r = pexp[0];
            else r = 8'($urandom);
            if ($urandom_range(0, 15) == 0) r = r ^ 8'($urandom_range(1, 255));
            result = r;
            zero = (r == 8'h00) ^ ($urandom_range(0, 31) == 0);
            if (clear) pexp.delete();
            else begin
                if (done && pexp.size() > 0) void'(pexp.pop_front());
                if (start) pexp.push_back(expected);
            end
            tick();
        end
        clear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
